// File: rtl/dpm_pkg.sv
// Shared definitions for the dual-port-memory port arbiter.
//   idx_w()  : requester-index width for a given requester count
//   rd_tag_t : read-tag pipeline stage {valid, requester index}
//   onehot() : requester index -> one-hot vector
// The tag index field is sized for the largest supported requester count
// (MAX_REQ); instances load only the low idx_w(NUM_REQ) bits, the rest stay 0.
package dpm_pkg;

  localparam int unsigned MAX_REQ   = 256;
  localparam int unsigned MAX_IDX_W = 8;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } rd_tag_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dpm_rr_grant.sv
// Combinational round-robin grant.
//   valid     : per-requester request valid
//   ptr       : highest-priority requester this cycle
//   grant     : one-hot grant, all zero when nothing is valid
//   grant_idx : index of the granted requester
//   grant_any : a grant is being issued
// Requests are rotated so ptr lands on bit 0, the lowest set bit is picked,
// and the pick is rotated back to an absolute index modulo NUM_REQ.
module dpm_rr_grant #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   pos;
  logic [IDX_W:0]     sum;

  always_comb begin
    rot = NUM_REQ'({valid, valid} >> ptr);

    pos = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (rot[i-1]) pos = IDX_W'(i - 1);
    end

    sum = {1'b0, ptr} + {1'b0, pos};
    if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);

    grant_any = |valid;
    grant_idx = sum[IDX_W-1:0];
    grant     = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/dpm_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_req_valid/we/addr/din: per-requester requests (packed slices)
//   o_req_ready            : one-hot grant (acceptance = valid & ready)
//   o_rsp_valid/o_rsp_data : one-hot read-data valid, shared read data
//   o_en/o_we/o_addr/o_din : registered memory command
//   i_dout                 : memory read data
//   o_busy                 : at least one read in flight
module dpm_port_arbiter
  import dpm_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ-1:0]         i_req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_din,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [NUM_REQ-1:0]         o_rsp_valid,
  output logic [WIDTH-1:0]           o_rsp_data,
  output logic                       o_en,
  output logic                       o_we,
  output logic [ADDR_WIDTH-1:0]      o_addr,
  output logic [WIDTH-1:0]           o_din,
  input  logic [WIDTH-1:0]           i_dout,
  output logic                       o_busy
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  // Stage 0 loads alongside the command register; the memory samples one
  // edge later and then takes READ_LATENCY edges, so the tag needs
  // READ_LATENCY+2 registers to line up with i_dout.
  localparam int unsigned NSTG  = READ_LATENCY + 2;

  logic [IDX_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_din;
  rd_tag_t               tags [NSTG];

  dpm_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_grant (
    .valid     (i_req_valid),
    .ptr       (rr_ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  assign o_req_ready = i_rst ? '0 : gnt;
  assign accept      = gnt_any & ~i_rst;

  always_comb begin
    sel_we   = i_req_we[gnt_idx];
    sel_addr = '0;
    sel_din  = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (IDX_W'(r) == gnt_idx) begin
        sel_addr = i_req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
        sel_din  = i_req_din[r*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_en   <= 1'b0;
      o_we   <= 1'b0;
      o_addr <= '0;
      o_din  <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      o_en   <= 1'b1;
      o_we   <= sel_we;
      o_addr <= sel_addr;
      o_din  <= sel_din;
      rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else begin
      o_en   <= 1'b0;
      o_we   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned s = 0; s < NSTG; s++) tags[s] <= '0;
    end else begin
      tags[0] <= '{valid: accept & ~sel_we, idx: MAX_IDX_W'(gnt_idx)};
      for (int unsigned s = 1; s < NSTG; s++) tags[s] <= tags[s-1];
    end
  end

  always_comb begin
    o_busy = 1'b0;
    for (int unsigned s = 0; s < NSTG; s++) o_busy = o_busy | tags[s].valid;
  end

  assign o_rsp_valid = tags[NSTG-1].valid ? NUM_REQ'(onehot(tags[NSTG-1].idx)) : '0;
  assign o_rsp_data  = i_dout;

endmodule

// File: tb/tb_dpm_port_arbiter.sv
module tb_dpm_port_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned RL = 2;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [NR-1:0] i_req_valid = '0;
  logic [NR-1:0] i_req_we = '0;
  logic [NR*AW-1:0] i_req_addr = '0;
  logic [NR*W-1:0]  i_req_din = '0;
  logic [NR-1:0] o_req_ready;
  logic [NR-1:0] o_rsp_valid;
  logic [W-1:0]  o_rsp_data;
  logic          o_en, o_we, o_busy;
  logic [AW-1:0] o_addr;
  logic [W-1:0]  o_din;
  logic [W-1:0]  i_dout;

  always #5 i_clk = ~i_clk;

  dpm_port_arbiter #(
    .NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW), .READ_LATENCY(RL)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_din(i_req_din),
    .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_en(o_en), .o_we(o_we), .o_addr(o_addr), .o_din(o_din),
    .i_dout(i_dout), .o_busy(o_busy)
  );

  // Memory port model: command sampled at an edge, data on i_dout RL edges later.
  logic [W-1:0] mem    [1<<AW];
  logic [W-1:0] refmem [1<<AW];
  logic [W-1:0] rd_pipe [RL+1];

  always @(posedge i_clk) begin
    if (o_en) begin
      if (o_we) mem[o_addr] <= o_din;
      else      rd_pipe[0]  <= mem[o_addr];
    end
    for (int k = 1; k <= RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign i_dout = rd_pipe[RL];

  typedef struct {
    int unsigned due;
    int unsigned idx;
    logic [W-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  typedef struct packed {
    logic          rst;
    logic [NR-1:0] valid;
    logic [NR-1:0] we;
    logic [NR*AW-1:0] addr;
    logic [NR*W-1:0]  din;
    logic [NR-1:0] exp_rdy;
  } vec_t;
  vec_t vt[$];

  int unsigned vecs = 0;
  int unsigned errs = 0;
  int unsigned cyc  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [NR*AW-1:0] pk(input logic [AW-1:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [NR*W-1:0] pd(input logic [W-1:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic void add(input logic r, input logic [NR-1:0] v, w,
                              input logic [NR*AW-1:0] a, input logic [NR*W-1:0] d,
                              input logic [NR-1:0] e);
    vt.push_back('{r, v, w, a, d, e});
  endfunction

  function automatic void idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) add(1'b0, '0, '0, '0, '0, '0);
  endfunction

  // One clock: drive, check grant mid-cycle, then check the registered
  // command and any response due after the edge.
  task automatic run_vec(input vec_t v);
    logic [NR-1:0] acc;
    int unsigned   idx;
    logic          e_en, e_we, e_busy;
    logic [AW-1:0] e_addr;
    logic [W-1:0]  e_din;
    i_rst       = v.rst;
    i_req_valid = v.valid;
    i_req_we    = v.we;
    i_req_addr  = v.addr;
    i_req_din   = v.din;
    @(negedge i_clk);
    chk("req_ready", 32'(o_req_ready), 32'(v.exp_rdy));
    acc = v.rst ? '0 : (v.valid & v.exp_rdy);
    idx = 0;
    for (int r = 0; r < NR; r++) if (acc[r]) idx = r;
    e_en   = |acc;
    e_we   = |(acc & v.we);
    e_addr = v.addr[idx*AW +: AW];
    e_din  = v.din[idx*W +: W];
    if (e_en) begin
      if (e_we) refmem[e_addr] = e_din;
      else sb.push_back('{cyc + 2 + RL, idx, refmem[e_addr]});
    end
    @(posedge i_clk);
    cyc++;
    #1;
    if (v.rst) sb.delete();
    chk("o_en", 32'(o_en), 32'(e_en));
    chk("o_we", 32'(o_we), 32'(e_we));
    if (e_en) begin
      chk("o_addr", 32'(o_addr), 32'(e_addr));
      chk("o_din", 32'(o_din), 32'(e_din));
    end
    if (v.rst) begin
      chk("rst_addr", 32'(o_addr), 32'd0);
      chk("rst_din", 32'(o_din), 32'd0);
    end
    e_busy = (sb.size() > 0);
    chk("o_busy", 32'(o_busy), 32'(e_busy));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("rsp_valid", 32'(o_rsp_valid), 32'(4'b0001 << sb[0].idx));
      chk("rsp_data", 32'(o_rsp_data), 32'(sb[0].data));
      void'(sb.pop_front());
    end else begin
      chk("rsp_idle", 32'(o_rsp_valid), 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]    = W'(a) ^ 8'h5A;
      refmem[a] = W'(a) ^ 8'h5A;
    end
    for (int k = 0; k <= RL; k++) rd_pipe[k] = '0;

    // reset, including requests presented while reset is high
    add(1, 4'b0000, 4'b0000, '0, '0, 4'b0000);
    add(1, 4'b1111, 4'b0000, pk(4, 3, 2, 1), '0, 4'b0000);
    // requester 2 reads 312 alone
    add(0, 4'b0100, 4'b0000, pk(0, 312, 0, 0), '0, 4'b0100);
    idle(4);
    // all four reading continuously from reset
    add(1, 4'b1111, 4'b0000, pk(40, 30, 20, 10), '0, 4'b0000);
    for (int i = 0; i < 8; i++)
      add(0, 4'b1111, 4'b0000, pk(40, 30, 20, 10), '0, 4'b0001 << (i % 4));
    idle(4);
    // requester 1 writes 22 to 202, requester 3 reads it back
    add(0, 4'b0010, 4'b0010, pk(0, 0, 202, 0), pd(0, 0, 8'd22, 0), 4'b0010);
    add(0, 4'b1000, 4'b0000, pk(202, 0, 0, 0), '0, 4'b1000);
    idle(4);
    // requesters 0 and 3 with rr_ptr at 3: wrap 3 -> 0 -> 1
    add(0, 4'b0100, 4'b0000, pk(0, 5, 0, 0), '0, 4'b0100);
    add(0, 4'b1001, 4'b0000, pk(7, 0, 0, 6), '0, 4'b1000);
    add(0, 4'b1001, 4'b0000, pk(7, 0, 0, 6), '0, 4'b0001);
    add(0, 4'b1001, 4'b0000, pk(8, 0, 0, 9), '0, 4'b1000);
    idle(4);
    // requester 2 valid for one cycle while 1 is granted, then dropped
    add(0, 4'b0110, 4'b0000, pk(0, 99, 98, 0), '0, 4'b0010);
    add(0, 4'b0000, 4'b0000, pk(0, 99, 98, 0), '0, 4'b0000);
    add(0, 4'b1000, 4'b0000, pk(11, 0, 0, 0), '0, 4'b1000);
    idle(4);

    foreach (vt[i]) run_vec(vt[i]);

    // reset while two reads from requester 0 are in flight
    v = '{0, 4'b0001, 4'b0000, pk(0, 0, 0, 50), '0, 4'b0001};
    run_vec(v);
    v = '{0, 4'b0001, 4'b0000, pk(0, 0, 0, 51), '0, 4'b0001};
    run_vec(v);
    v = '{1, 4'b0000, 4'b0000, '0, '0, 4'b0000};
    run_vec(v);
    v = '{0, 4'b0000, 4'b0000, '0, '0, 4'b0000};
    for (int i = 0; i < 4; i++) run_vec(v);
    // rr_ptr restarted at 0
    v = '{0, 4'b1111, 4'b0000, pk(63, 62, 61, 60), '0, 4'b0001};
    run_vec(v);
    v = '{0, 4'b0000, 4'b0000, '0, '0, 4'b0000};
    for (int i = 0; i < 4; i++) run_vec(v);

    vecs++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending responses expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
